// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - 8N1 UART receiver with oversampled bit timing and a first-word-fall-through byte FIFO
module uart_rx_decoder #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          UART_RXD,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    input  logic                          rd_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rx_s_q, rx_prev_q;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [OW-1:0]   os_cnt_q, os_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic [7:0]      push_data_q, push_data_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic tick, fall, fe_set, full, empty, pop, push_ok, ovr_set;

    assign tick = (div_cnt_q == DW'(DIV - 1));
    assign fall = rx_prev_q & ~rx_s_q;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        fe_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Restart the tick divider so the mid-bit sample lands at a fixed phase from the edge
                if (fall) begin
                    div_cnt_d = '0;
                    os_cnt_d  = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (os_cnt_q == OW'(OVERSAMPLE / 2 - 1)) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OW'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OW'(OVERSAMPLE - 1)) begin
                        os_cnt_d = '0;
                        if (rx_s_q) begin
                            push_d      = 1'b1;
                            push_data_d = shift_q;
                            state_d     = S_IDLE;
                        end else begin
                            fe_set  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        empty    = (count_q == '0);
        pop      = rd_ready & ~empty;
        // A pop in the same cycle frees the slot the incoming byte needs
        push_ok  = push_q & (~full | pop);
        ovr_set  = push_q & full & ~pop;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        frame_err_d = clr_flags ? 1'b0 : (frame_err_q | fe_set);
        overrun_d   = clr_flags ? 1'b0 : (overrun_q | ovr_set);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q     <= UART_RXD;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign fifo_count = count_q;

endmodule
